// File: rtl/c2h_sched_pkg.sv
// Shared types and defaults for the C2H descriptor-credit scheduler.
package c2h_sched_pkg;

  localparam int DEF_NUM_Q = 8;
  localparam int DEF_CRD_W = 16;
  localparam int DROP_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_FLUSH
  } sched_state_e;

endpackage

// File: rtl/c2h_rr_arb.sv
// Combinational round-robin picker: lowest eligible index at or after rr_ptr, with wrap.
module c2h_rr_arb
  import c2h_sched_pkg::*;
#(
  parameter int  NUM_Q = DEF_NUM_Q,
  localparam int QW    = $clog2(NUM_Q)
) (
  input  logic [NUM_Q-1:0] elig,
  input  logic [QW-1:0]    rr_ptr,
  output logic             any,
  output logic [QW-1:0]    winner
);

  logic [QW-1:0] idx;

  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      idx = rr_ptr + QW'(i);
      if (!any && elig[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/c2h_credit_sched.sv
// Per-queue C2H descriptor-credit scheduler: accumulates credits per queue and
// issues round-robin grants, one credit per grant; FLR flushes all state.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no grant outstanding; pick a winner if any queue is eligible
// ST_ISSUE | grant presented, held stable until req_rdy
// ST_DRAIN | one-cycle gap after the last grant before entering flush
// ST_FLUSH | FLR in progress: credits held clear, increments dropped
module c2h_credit_sched
  import c2h_sched_pkg::*;
#(
  parameter int          NUM_Q  = DEF_NUM_Q,
  parameter int          CRD_W  = DEF_CRD_W,
  parameter logic [7:0]  FNC_ID = 8'h00,
  localparam int         QW     = $clog2(NUM_Q)
) (
  input  logic               user_clk,
  input  logic               user_reset,
  input  logic               c2h_dsc_avail_inc_vld,
  input  logic [7:0]         c2h_dsc_avail_inc_qid,
  input  logic [15:0]        c2h_dsc_avail_inc_num,
  input  logic               flr_set,
  input  logic               flr_clr,
  input  logic [7:0]         flr_fnc,
  input  logic [NUM_Q-1:0]   q_en,
  output logic               req_vld,
  output logic [QW-1:0]      req_qid,
  input  logic               req_rdy,
  output logic               flr_busy,
  output logic [DROP_W-1:0]  drop_cnt,
  output logic               sat_err
);

  // One extra bit over the wider of counter and increment catches overflow.
  localparam int SUM_W = ((CRD_W > 16) ? CRD_W : 16) + 1;
  localparam logic [SUM_W-1:0] CR_MAX = {{(SUM_W-CRD_W){1'b0}}, {CRD_W{1'b1}}};

  sched_state_e       state, state_nxt;
  logic [CRD_W-1:0]   cr     [NUM_Q];
  logic [CRD_W-1:0]   cr_nxt [NUM_Q];
  logic [SUM_W-1:0]   sum    [NUM_Q];
  logic [NUM_Q-1:0]   sat_hit;
  logic [NUM_Q-1:0]   elig;
  logic [QW-1:0]      rr_ptr, rr_ptr_nxt, req_qid_nxt, winner, inc_idx;
  logic               req_vld_nxt, flr_pend, flr_pend_nxt, any;
  logic               flr_set_hit, flr_clr_hit, hs;
  logic               qid_ok, inc_live, inc_drop, inc_acc;

  assign flr_set_hit = flr_set && (flr_fnc == FNC_ID);
  assign flr_clr_hit = flr_clr && (flr_fnc == FNC_ID);
  assign hs          = req_vld && req_rdy;

  assign qid_ok   = c2h_dsc_avail_inc_qid < 8'(NUM_Q);
  assign inc_idx  = c2h_dsc_avail_inc_qid[QW-1:0];
  assign inc_live = c2h_dsc_avail_inc_vld && (c2h_dsc_avail_inc_num != 16'd0);
  assign inc_drop = inc_live && (!qid_ok || !q_en[inc_idx] || (state == ST_FLUSH));
  assign inc_acc  = inc_live && !inc_drop;

  always_comb begin
    for (int q = 0; q < NUM_Q; q++) begin
      elig[q]    = q_en[q] && (cr[q] != '0);
      sat_hit[q] = 1'b0;
      sum[q]     = SUM_W'(cr[q]);
      if (inc_acc && (inc_idx == QW'(q)))
        sum[q] = sum[q] + SUM_W'(c2h_dsc_avail_inc_num);
      // A grant on an empty queue completes without touching the credit.
      if (hs && (req_qid == QW'(q)) && (cr[q] != '0))
        sum[q] = sum[q] - SUM_W'(1);
      if (sum[q] > CR_MAX) begin
        cr_nxt[q]  = '1;
        sat_hit[q] = 1'b1;
      end else begin
        cr_nxt[q]  = sum[q][CRD_W-1:0];
      end
    end
  end

  c2h_rr_arb #(.NUM_Q(NUM_Q)) u_arb (
    .elig   (elig),
    .rr_ptr (rr_ptr),
    .any    (any),
    .winner (winner)
  );

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      for (int q = 0; q < NUM_Q; q++) cr[q] <= '0;
      sat_err  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      for (int q = 0; q < NUM_Q; q++) begin
        if ((state == ST_FLUSH) || !q_en[q]) cr[q] <= '0;
        else                                 cr[q] <= cr_nxt[q];
      end
      if (|sat_hit) sat_err <= 1'b1;
      if (inc_drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  always_comb begin
    state_nxt    = state;
    req_vld_nxt  = req_vld;
    req_qid_nxt  = req_qid;
    rr_ptr_nxt   = rr_ptr;
    flr_pend_nxt = flr_pend;
    case (state)
      ST_IDLE: begin
        if (flr_set_hit) begin
          state_nxt = ST_FLUSH;
        end else if (any) begin
          req_vld_nxt = 1'b1;
          req_qid_nxt = winner;
          state_nxt   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (flr_set_hit) flr_pend_nxt = 1'b1;
        if (hs) begin
          req_vld_nxt = 1'b0;
          rr_ptr_nxt  = req_qid + QW'(1);
          state_nxt   = (flr_pend || flr_set_hit) ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        flr_pend_nxt = 1'b0;
        state_nxt    = ST_FLUSH;
      end
      ST_FLUSH: begin
        rr_ptr_nxt = '0;
        if (flr_clr_hit && !flr_set_hit) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state    <= ST_IDLE;
      req_vld  <= 1'b0;
      req_qid  <= '0;
      rr_ptr   <= '0;
      flr_pend <= 1'b0;
      flr_busy <= 1'b0;
    end else begin
      state    <= state_nxt;
      req_vld  <= req_vld_nxt;
      req_qid  <= req_qid_nxt;
      rr_ptr   <= rr_ptr_nxt;
      flr_pend <= flr_pend_nxt;
      flr_busy <= (state_nxt == ST_FLUSH);
    end
  end

endmodule

// File: tb/tb_c2h_credit_sched.sv
// Scoreboard bench for c2h_credit_sched: expected grant qids are queued by the
// stimulus and popped by a negedge monitor on every req_vld & req_rdy handshake.
module tb_c2h_credit_sched;

  localparam int         NUM_Q = 8;
  localparam int         CRD_W = 4;
  localparam logic [7:0] FNC   = 8'h05;

  logic             clk;
  logic             user_reset;
  logic             inc_vld;
  logic [7:0]       inc_qid;
  logic [15:0]      inc_num;
  logic             flr_set, flr_clr;
  logic [7:0]       flr_fnc;
  logic [NUM_Q-1:0] q_en;
  logic             req_vld;
  logic [2:0]       req_qid;
  logic             req_rdy;
  logic             flr_busy;
  logic [15:0]      drop_cnt;
  logic             sat_err;

  c2h_credit_sched #(.NUM_Q(NUM_Q), .CRD_W(CRD_W), .FNC_ID(FNC)) dut (
    .user_clk              (clk),
    .user_reset            (user_reset),
    .c2h_dsc_avail_inc_vld (inc_vld),
    .c2h_dsc_avail_inc_qid (inc_qid),
    .c2h_dsc_avail_inc_num (inc_num),
    .flr_set               (flr_set),
    .flr_clr               (flr_clr),
    .flr_fnc               (flr_fnc),
    .q_en                  (q_en),
    .req_vld               (req_vld),
    .req_qid               (req_qid),
    .req_rdy               (req_rdy),
    .flr_busy              (flr_busy),
    .drop_cnt              (drop_cnt),
    .sat_err               (sat_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   exp_q[$];
  int   exp_pop;
  bit   mon_en   = 1'b0;
  logic stall_prev = 1'b0;
  logic [2:0] qid_prev = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_prev) begin
        chk("hold_vld", 32'(req_vld), 32'd1);
        chk("hold_qid", 32'(req_qid), 32'(qid_prev));
      end
      if (req_vld && req_rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_grant actual=%0d expected=none", req_qid);
        end else begin
          exp_pop = exp_q.pop_front();
          chk("grant_qid", 32'(req_qid), 32'(exp_pop));
        end
      end
      stall_prev = req_vld && !req_rdy;
      qid_prev   = req_qid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic inc(input int q, input int n);
    inc_vld = 1'b1;
    inc_qid = 8'(q);
    inc_num = 16'(n);
    tick(1);
    inc_vld = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick(6);
    chk({name, "_idle"}, 32'(req_vld), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    user_reset = 1'b1;
    inc_vld = 1'b0; inc_qid = '0; inc_num = '0;
    flr_set = 1'b0; flr_clr = 1'b0; flr_fnc = '0;
    q_en = '0; req_rdy = 1'b0;
    tick(3);
    user_reset = 1'b0;
    tick(1);
    chk("rst_req_vld",  32'(req_vld),  32'd0);
    chk("rst_req_qid",  32'(req_qid),  32'd0);
    chk("rst_flr_busy", 32'(flr_busy), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_sat_err",  32'(sat_err),  32'd0);
    q_en   = 8'hFF;
    mon_en = 1'b1;

    // Round-robin: q1=2, q5=2, q6=1 -> 1,5,6,1,5
    inc(1, 2); inc(5, 2); inc(6, 1);
    tick(3);
    foreach (exp_q[i]) exp_q.delete();
    exp_q.push_back(1); exp_q.push_back(5); exp_q.push_back(6);
    exp_q.push_back(1); exp_q.push_back(5);
    req_rdy = 1'b1;
    drain("rr", 40);

    // Basic: two credits on q3 -> two grants, then nothing
    exp_q.push_back(3); exp_q.push_back(3);
    inc(3, 2);
    drain("basic", 30);

    // Backpressure: grant held for 10 cycles, single decrement
    req_rdy = 1'b0;
    inc(2, 1);
    tick(10);
    chk("bp_vld", 32'(req_vld), 32'd1);
    chk("bp_qid", 32'(req_qid), 32'd2);
    exp_q.push_back(2);
    req_rdy = 1'b1;
    drain("bp", 20);

    // Drops: out-of-range qid, disabled queue; zero increment is not a drop
    inc(9, 1);
    tick(1);
    chk("drop_range", 32'(drop_cnt), 32'd1);
    q_en = 8'hEF;
    tick(1);
    inc(4, 3);
    tick(1);
    chk("drop_disabled", 32'(drop_cnt), 32'd2);
    inc(2, 0);
    tick(1);
    chk("drop_zero_num", 32'(drop_cnt), 32'd2);
    q_en = 8'hFF;
    tick(4);
    chk("drop_nogrant", 32'(req_vld), 32'd0);

    // Disable while a grant is pending: credit cleared, grant still completes
    req_rdy = 1'b0;
    inc(7, 3);
    tick(3);
    chk("pend_vld", 32'(req_vld), 32'd1);
    q_en = 8'h7F;
    tick(2);
    exp_q.push_back(7);
    req_rdy = 1'b1;
    drain("dis", 20);
    q_en = 8'hFF;
    tick(4);
    chk("dis_cleared", 32'(req_vld), 32'd0);

    // Saturation: cr0=14, +5 with a handshake on q0 same cycle -> 15
    chk("sat_pre", 32'(sat_err), 32'd0);
    req_rdy = 1'b0;
    inc(0, 14);
    tick(3);
    chk("sat_pend_qid", 32'(req_qid), 32'd0);
    for (int i = 0; i < 16; i++) exp_q.push_back(0);
    req_rdy = 1'b1;
    inc(0, 5);
    drain("sat", 60);
    chk("sat_err", 32'(sat_err), 32'd1);

    // FLR during ISSUE: grant completes, then DRAIN, FLUSH
    req_rdy = 1'b0;
    inc(2, 3);
    tick(3);
    flr_set = 1'b1; flr_fnc = FNC;
    tick(1);
    flr_set = 1'b0;
    tick(3);
    chk("flr_held_vld", 32'(req_vld), 32'd1);
    chk("flr_busy_pre", 32'(flr_busy), 32'd0);
    exp_q.push_back(2);
    req_rdy = 1'b1;
    tick(4);
    chk("flr_busy", 32'(flr_busy), 32'd1);
    chk("flr_vld", 32'(req_vld), 32'd0);
    inc(2, 4);
    tick(1);
    chk("flr_drop", 32'(drop_cnt), 32'd3);
    tick(3);
    chk("flr_nogrant", 32'(req_vld), 32'd0);
    flr_clr = 1'b1; flr_fnc = FNC;
    tick(1);
    flr_clr = 1'b0;
    tick(2);
    chk("flr_done", 32'(flr_busy), 32'd0);
    tick(4);
    chk("flr_flushed", 32'(req_vld), 32'd0);
    chk("flr_q_empty", 32'(exp_q.size()), 32'd0);

    // FLR for another function: ignored
    flr_set = 1'b1; flr_fnc = 8'h03;
    tick(1);
    flr_set = 1'b0;
    tick(2);
    chk("flr_other", 32'(flr_busy), 32'd0);
    exp_q.push_back(6);
    inc(6, 1);
    drain("post_flr", 20);

    // FLR in IDLE goes straight to FLUSH; set wins over clr
    flr_set = 1'b1; flr_fnc = FNC;
    tick(1);
    flr_set = 1'b0;
    tick(1);
    chk("flr_idle_busy", 32'(flr_busy), 32'd1);
    flr_set = 1'b1; flr_clr = 1'b1;
    tick(1);
    flr_set = 1'b0; flr_clr = 1'b0;
    tick(1);
    chk("flr_set_wins", 32'(flr_busy), 32'd1);
    flr_clr = 1'b1;
    tick(1);
    flr_clr = 1'b0;
    tick(1);
    chk("flr_idle_done", 32'(flr_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/c2h_credit_sched.md
# c2h_credit_sched

Per-queue C2H descriptor-credit scheduler. It sits between the QDMA fabric output signals and the user C2H packet generator. It accumulates descriptor-available increments per queue and grants C2H transfers round-robin among enabled queues that hold credit. Each grant consumes one descriptor credit. Function-level reset (FLR) flushes all state.

## Interface
Parameters:
- NUM_Q, 8: number of tracked queues; qid range 0..NUM_Q-1; power of two, 2..32.
- CRD_W, 16: per-queue credit counter width.
- FNC_ID, 0: PCIe function owned by this scheduler (8-bit).

Ports:
- user_clk  in  1  clock; reset is synchronous and active-high.
- user_reset  in  1  synchronous, active-high reset.
- c2h_dsc_avail_inc_vld  in  1  increment strobe.
- c2h_dsc_avail_inc_qid  in  8  target queue.
- c2h_dsc_avail_inc_num  in  16  descriptors added.
- flr_set  in  1  FLR start pulse.
- flr_clr  in  1  FLR done pulse.
- flr_fnc  in  8  function for flr_set/flr_clr.
- q_en  in  NUM_Q  per-queue enable (software configured).
- req_vld  out  1  transfer grant valid.
- req_qid  out  $clog2(NUM_Q)  granted queue.
- req_rdy  in  1  packet generator accepts grant.
- flr_busy  out  1  scheduler is in FLR.
- drop_cnt  out  16  dropped increments, saturating.
- sat_err  out  1  sticky: a credit counter saturated.

## Operation
- Credit array: cr[q], CRD_W bits per queue.
- Increment update rule: cr[q] is updated with min(cr[q] + inc_num − dec, 2^CRD_W − 1).
  - inc_num applies only when inc_vld is high and inc_qid == q.
  - dec = 1 when a req_vld & req_rdy handshake occurs on q and cr[q] > 0; otherwise dec = 0.
  - Saturation sets sat_err. sat_err clears only on user_reset.
- Dropped increment: inc_vld with any of the following increments drop_cnt (saturating at 0xFFFF) and leaves credits unchanged:
  - inc_qid ≥ NUM_Q;
  - q_en[inc_qid] == 0;
  - state is FLUSH.
- inc_num == 0: not a drop; no effect.
- Eligibility: elig[q] = q_en[q] & (cr[q] != 0).
- Queue disable: when q_en[q] falls, cr[q] is cleared to 0 on the next edge. Increments for q in that same cycle are dropped.
- FSM states: IDLE, ISSUE, DRAIN, FLUSH.
  - IDLE: if any elig, register the round-robin winner into req_qid, set req_vld = 1, go to ISSUE.
  - ISSUE: req_vld and req_qid are held stable until req_rdy. On the handshake, drop req_vld, set rr_ptr = req_qid + 1 (mod NUM_Q), then:
    - go to DRAIN if an FLR is pending;
    - otherwise go to IDLE.
  - FLR detection: flr_set with flr_fnc == FNC_ID.
    - Seen in IDLE: go to FLUSH directly.
    - Seen in ISSUE: latch flr_pend; the outstanding grant completes first.
  - DRAIN: one cycle, then go to FLUSH.
  - FLUSH: flr_busy = 1; all cr cleared, and held clear; rr_ptr = 0; increments dropped. Leave to IDLE on flr_clr with flr_fnc == FNC_ID.
- Non-matching flr_fnc: ignored.
- flr_set and flr_clr both high in the same cycle: flr_set wins.
- Handshake on a queue whose credit is 0 (e.g. disabled while pending): the credit stays 0, no underflow; the grant still completes.
- Round-robin: search starts at rr_ptr, lowest index at or after rr_ptr wins, with wrap-around.

## Timing
- Reset values:
  - outputs: req_vld = 0, req_qid = 0, flr_busy = 0, drop_cnt = 0, sat_err = 0;
  - internal: all cr = 0, rr_ptr = 0, state IDLE, flr_pend = 0.
- Outputs: all registered, no combinational input-to-output path.
- Latency:
  - An increment at edge N makes the queue eligible at N+1.
  - req_vld asserts at N+2 at the earliest (IDLE sampling elig at N+1).
- Throughput: at most one grant per two cycles (ISSUE → IDLE bubble).
- Handshake: the decrement is visible on the edge after req_vld & req_rdy.
- Mid-operation reset: user_reset overrides everything in the same edge. req_vld drops with no handshake.

## Structure
- Package c2h_sched_pkg holds:
  - the state enum (IDLE, ISSUE, DRAIN, FLUSH);
  - the default NUM_Q and CRD_W localparams;
  - the drop-counter width.
- Sub-module c2h_rr_arb: parameterized NUM_Q round-robin picker.
  - Inputs: elig, rr_ptr.
  - Outputs: any, winner index.
  - Purely combinational; the winner is registered in the parent.
- The credit array lives in the top level as flops; no RAM.

## Test plan
- Basic grants: q_en = 0xFF; inc qid 3, num 2 → two grants with req_qid = 3; cr[3] returns to 0; no third grant.
- Round-robin fairness: credits q1 = 2, q5 = 2, q6 = 1, req_rdy tied high → grant order 1, 5, 6, 1, 5.
- Backpressure: req_rdy low for 10 cycles → req_vld and req_qid stable throughout; single decrement after req_rdy rises.
- Drops: inc with qid 9 (NUM_Q = 8) → drop_cnt = 1; inc to a disabled queue → drop_cnt = 2; credits unchanged.
- Saturation and simultaneous events: CRD_W = 4, cr = 14, inc num 5 with a handshake on the same queue in the same cycle → cr = 15, sat_err = 1.
- FLR: flr_set with fnc = FNC_ID while ISSUE on q2 → grant held until req_rdy; then DRAIN, then FLUSH; flr_busy = 1; all cr = 0; increments counted as drops; flr_clr → IDLE.
- FLR, other function: flr_set with fnc ≠ FNC_ID → no effect.
